// File: rtl/rv_fetch_queue_if.sv
// rtl/rv_fetch_queue_if.sv - fetch/decode and instruction-memory handshake bundle for rv_fetch_queue
interface rv_fetch_queue_if;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        instr_ready_i;

    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output instr_valid_o,
        output instr_o,
        output pc_o,
        input  instr_ready_i
    );

    modport slave (
        output redirect_i,
        output redirect_pc_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  instr_valid_o,
        input  instr_o,
        input  pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - sequential instruction fetch with a single outstanding request and a prefetch queue
module rv_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [PW-1:0] ptr_t;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    ptr_t          wptr_q, wptr_d;
    ptr_t          rptr_q, rptr_d;
    logic [63:0]   pc_mem_q [DEPTH];
    logic [63:0]   pc_mem_d [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic issue;
    logic resp;
    logic push;
    logic pop;
    logic head_valid;

    // Credit check counts the outstanding word so a returning response always has a slot.
    always_comb begin
        issue      = !rst_i && !bus.redirect_i && (!inflight_q || bus.imem_rvalid_i)
                     && ((count_q + CW'(inflight_q)) < DEPTH_C);
        resp       = bus.imem_rvalid_i && inflight_q;
        push       = resp && !drop_q && !bus.redirect_i;
        head_valid = !rst_i && (count_q != '0);
        pop        = head_valid && bus.instr_ready_i && !bus.redirect_i;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (bus.redirect_i) begin
            fetch_pc_d = bus.redirect_pc_i & ~64'h3;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            // A request still in flight keeps its slot but its word must be thrown away.
            inflight_d = inflight_q && !bus.imem_rvalid_i;
            drop_d     = inflight_q && !bus.imem_rvalid_i;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end else if (resp) begin
                inflight_d = 1'b0;
            end

            if (resp && drop_q) begin
                drop_d = 1'b0;
            end

            if (push) begin
                pc_mem_d[wptr_q]    = req_pc_q;
                instr_mem_d[wptr_q] = bus.imem_rdata_i;
                wptr_d              = wptr_q + ptr_t'(1);
            end

            if (pop) begin
                rptr_d = rptr_q + ptr_t'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 64'h0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Queue storage needs no reset: the head is only visible while count is nonzero.
    always_ff @(posedge clk_i) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head_valid ? instr_mem_q[rptr_q] : NOP;
    assign bus.pc_o          = head_valid ? pc_mem_q[rptr_q] : 64'h0;
endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb/tb_rv_fetch_queue.sv - directed and scoreboarded checks of rv_fetch_queue against a latency-programmable memory
module tb_rv_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   lat;

    logic        s_req;
    logic [63:0] s_addr;
    logic        pend;
    logic [63:0] paddr;
    int          cnt;
    logic [63:0] exp_pc;

    rv_fetch_queue_if bus ();

    rv_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h1000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Memory responder: one outstanding request, answered lat cycles after it is issued.
    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        pend = 1'b0;
        paddr = 64'h0;
        cnt = 0;
        forever begin
            @(negedge clk);
            s_req  = bus.imem_req_o;
            s_addr = bus.imem_addr_o;
            @(posedge clk);
            #1;
            if (s_req) begin
                pend  = 1'b1;
                paddr = s_addr;
                cnt   = (lat == 0) ? int'($urandom_range(1, 5)) - 1 : lat - 1;
            end
            if (pend && cnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem(paddr);
                pend = 1'b0;
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = 32'h0;
                if (pend) cnt--;
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        lat   = 1;
        rst   = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 64'h0;
        bus.instr_ready_i = 1'b1;

        nxt(); nxt(); settle();
        check("rst_req",   64'(bus.imem_req_o), 64'd0);
        check("rst_valid", 64'(bus.instr_valid_o), 64'd0);
        check("rst_instr", 64'(bus.instr_o), 64'(NOP));
        check("rst_pc",    bus.pc_o, 64'h0);

        nxt(); rst = 1'b0; settle();
        check("first_req",   64'(bus.imem_req_o), 64'd1);
        check("first_addr",  bus.imem_addr_o, 64'h1000);
        check("first_valid", 64'(bus.instr_valid_o), 64'd0);
        nxt(); settle();
        check("b2b_addr",  bus.imem_addr_o, 64'h1004);
        check("b2b_valid", 64'(bus.instr_valid_o), 64'd0);
        for (int k = 0; k < 8; k++) begin
            nxt(); settle();
            check("stream_valid", 64'(bus.instr_valid_o), 64'd1);
            check("stream_pc",    bus.pc_o, 64'h1000 + 64'(4 * k));
            check("stream_instr", 64'(bus.instr_o), 64'(mem(64'h1000 + 64'(4 * k))));
            check("stream_addr",  bus.imem_addr_o, 64'h1008 + 64'(4 * k));
        end

        nxt(); bus.instr_ready_i = 1'b0; settle();
        check("stall_head", bus.pc_o, 64'h1020);
        for (int k = 0; k < 19; k++) begin
            nxt(); settle();
        end
        check("full_req",   64'(bus.imem_req_o), 64'd0);
        check("full_valid", 64'(bus.instr_valid_o), 64'd1);
        check("full_head",  bus.pc_o, 64'h1020);
        check("full_count", 64'(dut.count_q), 64'd4);

        nxt(); bus.instr_ready_i = 1'b1; settle();
        check("drain_req0", 64'(bus.imem_req_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                nxt(); settle();
            end
            check("drain_valid", 64'(bus.instr_valid_o), 64'd1);
            check("drain_pc",    bus.pc_o, 64'h1020 + 64'(4 * i));
            if (i == 1) begin
                check("resume_req",  64'(bus.imem_req_o), 64'd1);
                check("resume_addr", bus.imem_addr_o, 64'h1030);
            end
        end

        nxt(); rst = 1'b1; lat = 3; settle();
        check("pulse_req",   64'(bus.imem_req_o), 64'd0);
        check("pulse_valid", 64'(bus.instr_valid_o), 64'd0);
        check("pulse_instr", 64'(bus.instr_o), 64'(NOP));
        check("pulse_pc",    bus.pc_o, 64'h0);
        nxt(); rst = 1'b0; settle();
        check("restart_valid", 64'(bus.instr_valid_o), 64'd0);
        check("restart_addr",  bus.imem_addr_o, 64'h1000);
        check("restart_req",   64'(bus.imem_req_o), 64'd1);

        nxt(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h2002; settle();
        check("redir_req", 64'(bus.imem_req_o), 64'd0);
        nxt(); bus.redirect_i = 1'b0; lat = 1; settle();
        check("stale_wait_req",   64'(bus.imem_req_o), 64'd0);
        check("stale_wait_valid", 64'(bus.instr_valid_o), 64'd0);
        nxt(); settle();
        check("stale_ret_req",   64'(bus.imem_req_o), 64'd1);
        check("stale_ret_addr",  bus.imem_addr_o, 64'h2000);
        check("stale_ret_valid", 64'(bus.instr_valid_o), 64'd0);
        nxt(); settle();
        check("stale_dropped", 64'(bus.instr_valid_o), 64'd0);
        check("redir_addr2",   bus.imem_addr_o, 64'h2004);
        nxt(); settle();
        check("redir_valid", 64'(bus.instr_valid_o), 64'd1);
        check("redir_pc",    bus.pc_o, 64'h2000);
        check("redir_instr", 64'(bus.instr_o), 64'(mem(64'h2000)));

        nxt(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h3000; settle();
        check("popredir_head",   bus.pc_o, 64'h2004);
        check("popredir_rvalid", 64'(bus.imem_rvalid_i), 64'd1);
        check("popredir_req",    64'(bus.imem_req_o), 64'd0);
        nxt(); bus.redirect_i = 1'b0; settle();
        check("popredir_empty", 64'(bus.instr_valid_o), 64'd0);
        check("popredir_addr",  bus.imem_addr_o, 64'h3000);
        nxt(); settle();
        check("popredir_empty2", 64'(bus.instr_valid_o), 64'd0);
        nxt(); settle();
        check("popredir_pc", bus.pc_o, 64'h3000);

        nxt(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC; settle();
        check("wrap_redir_req", 64'(bus.imem_req_o), 64'd0);
        nxt(); bus.redirect_i = 1'b0; settle();
        check("wrap_addr_top", bus.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt(); settle();
        check("wrap_addr_zero", bus.imem_addr_o, 64'h0);
        check("wrap_req_zero",  64'(bus.imem_req_o), 64'd1);
        nxt(); settle();
        check("wrap_pc_top", bus.pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt(); settle();
        check("wrap_pc_zero",    bus.pc_o, 64'h0);
        check("wrap_instr_zero", 64'(bus.instr_o), 64'(mem(64'h0)));

        lat = 0;
        nxt(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h4000; settle();
        exp_pc = 64'h4000;
        for (int c = 0; c < 400; c++) begin
            nxt();
            bus.redirect_i    = 1'b0;
            bus.instr_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                bus.redirect_i    = 1'b1;
                bus.redirect_pc_i = {$urandom, $urandom};
            end
            settle();
            check("rand_count_bound", 64'(dut.count_q <= 3'd4), 64'd1);
            if (bus.redirect_i) begin
                exp_pc = bus.redirect_pc_i & ~64'h3;
            end else if (bus.instr_valid_o && bus.instr_ready_i) begin
                check("rand_pc",    bus.pc_o, exp_pc);
                check("rand_instr", 64'(bus.instr_o), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 64'd4;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
